// File: rtl/pe_pkg.sv
// Shared processing-element definitions: default datapath widths, accumulator
// limits and the psum accumulator state encoding.
package pe_pkg;

  localparam int BIT_WIDTH   = 8;
  localparam int ACC_WIDTH   = 16;
  localparam int COUNT_WIDTH = 8;

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/sat_adder.sv
// Combinational signed saturating adder: one guard bit of headroom, then clamp
// to the representable range and flag when clamping happened.
module sat_adder #(
  parameter int accWidth = pe_pkg::ACC_WIDTH
) (
  input  logic signed [accWidth-1:0] a,
  input  logic signed [accWidth-1:0] b,
  output logic signed [accWidth-1:0] sum,
  output logic                       overflow
);

  localparam logic signed [accWidth-1:0] SAT_MAX = {1'b0, {(accWidth-1){1'b1}}};
  localparam logic signed [accWidth-1:0] SAT_MIN = {1'b1, {(accWidth-1){1'b0}}};

  logic signed [accWidth:0] wide;

  assign wide = {a[accWidth-1], a} + {b[accWidth-1], b};

  // The two top bits disagree exactly when the true sum left the narrow range;
  // the guard bit then gives the direction of the overflow.
  assign overflow = wide[accWidth] ^ wide[accWidth-1];

  always_comb begin
    if (!overflow) begin
      sum = wide[accWidth-1:0];
    end else if (wide[accWidth]) begin
      sum = SAT_MIN;
    end else begin
      sum = SAT_MAX;
    end
  end

endmodule

// File: rtl/saturating_psum_accumulator.sv
// Accumulates cfg_len signed products onto an incoming partial sum with
// per-add saturation and hands the result downstream over valid/ready.
module saturating_psum_accumulator
  import pe_pkg::*;
#(
  parameter int bitWidth   = BIT_WIDTH,
  parameter int accWidth   = ACC_WIDTH,
  parameter int countWidth = COUNT_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic        [countWidth-1:0] cfg_len,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [bitWidth-1:0]   in_product,
  input  logic signed [accWidth-1:0]   psum_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [accWidth-1:0]   psum_out,
  output logic                         sat_flag
);

  state_t                       state, state_nxt;
  logic signed [accWidth-1:0]   acc, acc_nxt;
  logic        [countWidth-1:0] count, count_nxt;
  logic        [countWidth-1:0] len_q, len_nxt;
  logic                         sat_q, sat_nxt;

  logic                         accept;
  logic        [countWidth-1:0] cfg_len_eff;
  logic signed [accWidth-1:0]   prod_ext;
  logic signed [accWidth-1:0]   add_a;
  logic signed [accWidth-1:0]   add_sum;
  logic                         add_ovf;

  assign in_ready = (state != OUT);
  assign accept   = in_valid && in_ready;

  assign cfg_len_eff = (cfg_len == '0) ? countWidth'(1) : cfg_len;
  assign prod_ext    = accWidth'(in_product);

  // The first beat of a psum adds onto psum_in; later beats add onto acc.
  assign add_a = (state == IDLE) ? psum_in : acc;

  sat_adder #(
    .accWidth(accWidth)
  ) u_sat_adder (
    .a       (add_a),
    .b       (prod_ext),
    .sum     (add_sum),
    .overflow(add_ovf)
  );

  // NOTE: every next-state variable takes its hold value first, so no path
  // through the case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    count_nxt = count;
    len_nxt   = len_q;
    sat_nxt   = sat_q;

    unique case (state)
      IDLE: begin
        if (accept) begin
          acc_nxt   = add_sum;
          len_nxt   = cfg_len_eff;
          count_nxt = countWidth'(1);
          sat_nxt   = add_ovf;
          state_nxt = (cfg_len_eff == countWidth'(1)) ? OUT : ACC;
        end
      end
      ACC: begin
        if (accept) begin
          acc_nxt   = add_sum;
          count_nxt = count + countWidth'(1);
          sat_nxt   = sat_q | add_ovf;
          if (count_nxt == len_q) begin
            state_nxt = OUT;
          end
        end
      end
      OUT: begin
        if (out_ready) begin
          state_nxt = IDLE;
          count_nxt = '0;
          sat_nxt   = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // NOTE: registers use non-blocking assignment so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
      len_q <= '0;
      sat_q <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      count <= count_nxt;
      len_q <= len_nxt;
      sat_q <= sat_nxt;
    end
  end

  // Outputs come straight from registered state, so they hold steady while
  // the downstream stalls and never depend combinationally on out_ready.
  assign out_valid = (state == OUT);
  assign psum_out  = acc;
  assign sat_flag  = out_valid & sat_q;

endmodule

// File: tb/tb_saturating_psum_accumulator.sv
// Self-checking bench: a reference model predicts each psum when its beats are
// driven; a monitor pops and compares on every output handshake.
module tb_saturating_psum_accumulator;

  localparam int ACC_MAX_I = 32767;
  localparam int ACC_MIN_I = -32768;

  typedef struct {
    int psum;
    int sat;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic        [7:0]  cfg_len;
  logic               in_valid;
  logic               in_ready;
  logic signed [7:0]  in_product;
  logic signed [15:0] psum_in;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] psum_out;
  logic               sat_flag;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  int   prods[$];

  saturating_psum_accumulator #(
    .bitWidth  (8),
    .accWidth  (16),
    .countWidth(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_len   (cfg_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_product(in_product),
    .psum_in   (psum_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .psum_out  (psum_out),
    .sat_flag  (sat_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: per-add clamp, sticky saturation flag.
  function automatic exp_t model(input int pin, input int len);
    exp_t e;
    int   s;
    e.psum = pin;
    e.sat  = 0;
    for (int i = 0; i < ((len == 0) ? 1 : len); i++) begin
      s = e.psum + prods[i];
      if (s > ACC_MAX_I) begin
        s = ACC_MAX_I;
        e.sat = 1;
      end else if (s < ACC_MIN_I) begin
        s = ACC_MIN_I;
        e.sat = 1;
      end
      e.psum = s;
    end
    return e;
  endfunction

  // Scoreboard monitor: sample away from the rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        e = sb.pop_front();
        check("psum", int'(psum_out), e.psum);
        check("sat", int'(sat_flag), e.sat);
      end
    end
  end

  // Present one beat and hold it until the DUT takes it (bounded wait).
  task automatic beat(input int p, input int pin, input int len);
    int n = 0;
    in_valid   = 1'b1;
    in_product = p[7:0];
    psum_in    = pin[15:0];
    cfg_len    = len[7:0];
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 50) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid   = 1'b0;
    in_product = 8'($urandom);
    cfg_len    = 8'($urandom);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run_psum(input int pin, input int len);
    sb.push_back(model(pin, len));
    for (int i = 0; i < ((len == 0) ? 1 : len); i++) begin
      beat(prods[i], pin, len);
    end
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_product = '0;
    psum_in    = '0;
    cfg_len    = '0;
    out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_psum_out", int'(psum_out), 0);
    check("rst_sat_flag", int'(sat_flag), 0);

    // Normal accumulation with latency check on the last beat.
    prods = {3, -2, 5, 7};
    run_psum(10, 4);
    check("lat_out_valid", int'(out_valid), 1);
    check("lat_in_ready", int'(in_ready), 0);
    idle(1);
    check("back_to_idle", int'(in_ready), 1);

    // Positive saturation, not undone by the later negative term.
    prods = {100, -50};
    run_psum(32760, 2);

    // Negative saturation and the cfg_len == 0 case.
    prods = {-1};
    run_psum(-32768, 1);
    prods = {5};
    run_psum(0, 0);
    idle(1);

    // Bubbles: only valid beats advance the term count.
    prods = {1, 2, 4};
    sb.push_back(model(-100, 3));
    beat(1, -100, 3);
    idle(2);
    check("bubble_no_early_out", int'(out_valid), 0);
    beat(2, 1234, 1);
    idle(1);
    beat(4, 1234, 1);
    idle(1);

    // Backpressure: held output, no beat consumed while stalled.
    out_ready = 1'b0;
    prods = {7};
    run_psum(100, 1);
    prods = {20};
    sb.push_back(model(0, 1));
    in_valid   = 1'b1;
    in_product = 8'd20;
    psum_in    = 16'd0;
    cfg_len    = 8'd1;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_psum_stable", int'(psum_out), 107);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_idle", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_accepted", int'(out_valid), 1);
    idle(1);

    // Reset mid-operation drops the partial psum.
    beat(50, 300, 4);
    beat(60, 300, 4);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_psum_out", int'(psum_out), 0);
    prods = {9};
    run_psum(0, 1);
    idle(1);

    // Randomised psums with extreme psum_in values and occasional stalls.
    for (int k = 0; k < 8; k++) begin
      int len;
      int pin;
      len = $urandom_range(0, 5);
      pin = (k % 3 == 0) ? 32700 : (k % 3 == 1) ? -32700 : int'($urandom_range(0, 2000)) - 1000;
      prods = {};
      for (int i = 0; i < ((len == 0) ? 1 : len); i++) begin
        prods.push_back(int'($urandom_range(0, 255)) - 128);
      end
      out_ready = (k % 2 == 0);
      run_psum(pin, len);
      idle(2);
      out_ready = 1'b1;
      idle(1);
    end

    begin
      int n = 0;
      while (sb.size() != 0 && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      check("scoreboard_drained", sb.size(), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
